// File: rtl/aes_cbc_dec.sv
// AES-128 CBC decryption wrapper around an iterative inverse-cipher core.
// The chain register tracks the previous ciphertext and advances only when a plaintext block is produced.
module aes_inv_cipher (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic         start_i,
    input  logic [127:0] block_i,
    output logic         done_o,
    output logic [127:0] block_o
);
    logic [127:0] rk_q [0:10];
    logic [127:0] kw_q, st_q, out_q, kw_d, rnd_t;
    logic [7:0]   rcon_q;
    logic [3:0]   kidx_q, rnd_q;
    logic         kbusy_q, kready_q, busy_q, done_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] w, input logic [7:0] rcon);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(w[23:16]) ^ rcon, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
        n0 = w[127:96] ^ t;
        n1 = w[95:64] ^ n0;
        n2 = w[63:32] ^ n1;
        n3 = w[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte b of the state lives at [127-8b -: 8], column-major (b = 4*col + row).
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign kw_d  = expand_key(kw_q, rcon_q);
    assign rnd_t = inv_sub_shift(st_q) ^ rk_q[rnd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbusy_q  <= 1'b0;
            kready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            kidx_q   <= 4'd0;
            rnd_q    <= 4'd0;
            rcon_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (key_valid_i) begin
                kbusy_q  <= 1'b1;
                kready_q <= 1'b0;
                busy_q   <= 1'b0;
                kidx_q   <= 4'd1;
                rcon_q   <= 8'h01;
            end else begin
                if (kbusy_q) begin
                    rcon_q <= xtime(rcon_q);
                    kidx_q <= kidx_q + 4'd1;
                    if (kidx_q == 4'd10) begin
                        kbusy_q  <= 1'b0;
                        kready_q <= 1'b1;
                    end
                end
                if (busy_q) begin
                    if (rnd_q == 4'd0) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q - 4'd1;
                    end
                end else if (start_i && kready_q) begin
                    busy_q <= 1'b1;
                    rnd_q  <= 4'd9;
                end
            end
        end
    end

    // Round keys and datapath state carry no reset; control flags gate their use.
    always_ff @(posedge clk) begin
        if (key_valid_i) begin
            rk_q[0] <= key_i;
            kw_q    <= key_i;
        end else if (kbusy_q) begin
            rk_q[kidx_q] <= kw_d;
            kw_q         <= kw_d;
        end
        if (busy_q) begin
            if (rnd_q == 4'd0) out_q <= rnd_t;
            else               st_q  <= inv_mix(rnd_t);
        end else if (start_i && kready_q) begin
            st_q <= block_i ^ rk_q[10];
        end
    end

    assign key_ready_o = kready_q;
    assign done_o      = done_q;
    assign block_o     = out_q;
endmodule

module aes_cbc_dec (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [127:0] iv_i,
    input  logic         iv_valid_i,
    input  logic [127:0] din_i,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    output logic [127:0] dout_o,
    output logic         dout_valid_o
);
    typedef enum logic [2:0] {NOKEY, KEYEXP, READY, BUSY, OUT} state_t;

    state_t       state_q, state_d;
    logic [127:0] chain_q, chain_d, held_q, held_d, dout_q, dout_d;
    logic [127:0] core_out;
    logic         core_key_ready, core_start, core_done;

    aes_inv_cipher u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_i       (key_i),
        .key_valid_i (key_valid_i),
        .key_ready_o (core_key_ready),
        .start_i     (core_start),
        .block_i     (din_i),
        .done_o      (core_done),
        .block_o     (core_out)
    );

    always_comb begin
        state_d    = state_q;
        chain_d    = chain_q;
        held_d     = held_q;
        dout_d     = dout_q;
        core_start = 1'b0;
        // A key load overrides everything and silently drops any block in flight.
        if (key_valid_i) begin
            state_d = KEYEXP;
        end else begin
            case (state_q)
                NOKEY:  state_d = NOKEY;
                KEYEXP: if (core_key_ready) state_d = READY;
                READY: begin
                    if (din_valid_i) begin
                        state_d    = BUSY;
                        held_d     = din_i;
                        core_start = 1'b1;
                    end
                end
                BUSY: begin
                    if (core_done) begin
                        state_d = OUT;
                        dout_d  = core_out ^ chain_q;
                    end
                end
                OUT: begin
                    state_d = READY;
                    chain_d = held_q;
                end
                default: state_d = NOKEY;
            endcase
        end
        if (iv_valid_i && (key_valid_i || !(state_q == BUSY || state_q == OUT)))
            chain_d = iv_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NOKEY;
            chain_q <= '0;
            held_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            held_q  <= held_d;
            dout_q  <= dout_d;
        end
    end

    assign key_ready_o  = (state_q == READY) || (state_q == BUSY) || (state_q == OUT);
    assign din_ready_o  = (state_q == READY);
    assign dout_valid_o = (state_q == OUT);
    assign dout_o       = dout_q;
endmodule

// File: doc/aes_cbc_dec.md
AES_CBC_DEC -- requirements
Module: aes_cbc_dec

Interface
REQ-001 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- key_i  in  128  AES-128 key.
- key_valid_i  in  1  key load strobe.
- key_ready_o  out  1  key schedule complete; block usable.
- iv_i  in  128  initial chaining value.
- iv_valid_i  in  1  IV load strobe.
- din_i  in  128  ciphertext block.
- din_valid_i  in  1  ciphertext strobe.
- din_ready_o  out  1  block accepts ciphertext this cycle.
- dout_o  out  128  plaintext block.
- dout_valid_o  out  1  one-cycle plaintext strobe.
REQ-002 SHALL use one clock domain and an asynchronous active-low reset, exactly as stated in REQ-001.
REQ-003 SHALL instantiate the team's existing aes_inv_cipher core for AES-128 inverse cipher.
- Core interface: key/key_valid/key_ready, start + 128-bit block in, done + 128-bit block out.
- Core latency is variable; the FSM SHALL wait on done and SHALL NOT count cycles.

Function
REQ-004 FSM states SHALL be: NOKEY, KEYEXP, READY, BUSY, OUT.
REQ-005 NOKEY: on key_valid_i=1, SHALL forward key_i to the core and go to KEYEXP.
REQ-006 KEYEXP: on core key_ready, SHALL go to READY and drive key_ready_o=1.
- key_ready_o SHALL stay 1 until the next key load or reset.
REQ-007 iv_valid_i=1 SHALL load iv_i into the 128-bit chain register in any state except BUSY/OUT.
- In BUSY/OUT it SHALL be ignored.
- If iv_valid_i and key_valid_i arrive in the same cycle, both SHALL load.
REQ-008 din_ready_o SHALL be 1 only in READY, and combinational from state.
REQ-009 READY with din_valid_i=1:
- SHALL capture din_i into the held-ciphertext register.
- SHALL pulse core start with din_i.
- SHALL go to BUSY.
- din_valid_i while din_ready_o=0 SHALL be dropped and not queued.
REQ-010 BUSY: on core done, SHALL go to OUT.
- SHALL register dout_o = core_out XOR chain.
- SHALL assert dout_valid_o.
REQ-011 OUT (one cycle):
- dout_valid_o=1 for exactly one cycle.
- Chain register SHALL load the held ciphertext.
- SHALL return to READY.
- Throughput: at most one block per (core latency + 2) cycles.
REQ-012 dout_o SHALL hold its last value while dout_valid_o=0.
REQ-013 key_valid_i in any state SHALL:
- restart key expansion, going to KEYEXP;
- drop key_ready_o;
- discard any in-flight block with no dout_valid_o pulse;
- leave the chain register unchanged unless iv_valid_i is also 1.
REQ-014 din_valid_i in NOKEY/KEYEXP SHALL be ignored.
REQ-015 The XOR SHALL be a full 128-bit bitwise XOR with byte 0 at bits [127:120], the same ordering as din_i/dout_o.
REQ-016 The chain register SHALL advance only on a produced block, so any ciphertext stream order decrypts identically to software CBC.

Reset
REQ-017 While rst_n=0, regardless of clk:
- state SHALL be NOKEY;
- key_ready_o=0, din_ready_o=0, dout_valid_o=0;
- dout_o, chain register and held-ciphertext register SHALL be all zeros.
REQ-018 Reset asserted mid-block SHALL abort the block with no output pulse.
REQ-019 After reset release, a key SHALL be reloaded before any data is accepted.

Verification
All vectors use key 2b7e151628aed2a6abf7158809cf4f3c and IV 000102030405060708090a0b0c0d0e0f.
REQ-020 Single block: din 7649abac8119b246cee98e9b12e9197d -> dout 6bc1bee22e409f96e93d7e117393172a, one dout_valid_o pulse.
REQ-021 Four back-to-back blocks (7649abac..., 5086cb9b507219ee95db113a917678b2, 73bed6b8e3c1743b7116e69e22229516, 3ff1caa1681fac09120eca307586e1a7), offered with random valid gaps. Expected plaintexts in order:
- 6bc1bee2...
- ae2d8a571e03ac9c9eb76fac45af8e51
- 30c81c46a35ce411e5fbc1191a0a52ef
- f69f2445df4f9b17ad2b417be66c3710
- Exactly 4 pulses.
REQ-022 din_valid_i held high continuously: each block consumed only when din_ready_o=1; no duplicates, no drops; same 4 outputs as REQ-021.
REQ-023 IV reload between blocks 2 and 3, with iv 7649abac8119b246cee98e9b12e9197d... (that is, ciphertext block 1 reused as IV) and block 5086cb9b... fed -> dout ae2d8a571e03ac9c9eb76fac45af8e51.
REQ-024 rst_n low for one cycle while BUSY:
- all outputs zero immediately (asynchronous);
- no dout_valid_o pulse;
- after reload of key and IV, REQ-020 passes.
REQ-025 key_valid_i asserted during BUSY:
- key_ready_o falls next cycle;
- no dout_valid_o for the aborted block;
- din_ready_o stays 0 until key_ready_o=1.
